// File: rtl/br_predictor.sv
// Bimodal branch direction predictor: 2-bit saturating counter table,
// one-cycle prediction latency, single commit-time update port and statistics.
module br_predictor #(
  parameter int BHT_IDX_WIDTH = 8,
  parameter int STAT_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     query_valid_from_inst_fetcher,
  input  logic [BHT_IDX_WIDTH-1:0] query_pc_from_inst_fetcher,
  input  logic                     valid_from_rob_bus,
  input  logic [BHT_IDX_WIDTH-1:0] pc_from_rob_bus,
  input  logic                     is_taken_from_rob_bus,
  input  logic                     reset_from_rob_bus,
  output logic                     pred_valid_to_inst_fetcher,
  output logic                     pred_taken_to_inst_fetcher,
  output logic [STAT_WIDTH-1:0]    update_count,
  output logic [STAT_WIDTH-1:0]    mispredict_count
);

  localparam int DEPTH = 1 << BHT_IDX_WIDTH;

  logic [1:0]            bht_q [DEPTH];
  logic [1:0]            cnt_cur;
  logic [1:0]            cnt_d;
  logic                  upd_en;
  logic                  mispred;
  logic                  accept;
  logic                  pred_valid_q, pred_valid_d;
  logic                  pred_taken_q, pred_taken_d;
  logic [STAT_WIDTH-1:0] upd_cnt_q, upd_cnt_d;
  logic [STAT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;

  assign upd_en  = rdy & valid_from_rob_bus;
  assign cnt_cur = bht_q[pc_from_rob_bus];
  assign mispred = cnt_cur[1] ^ is_taken_from_rob_bus;
  // Flush drops the query but never blocks the update
  assign accept  = rdy & query_valid_from_inst_fetcher
                 & ~reset_from_rob_bus;

  always_comb begin
    cnt_d = cnt_cur;
    if (is_taken_from_rob_bus) begin
      if (cnt_cur != 2'b11) cnt_d = cnt_cur + 2'd1;
    end else begin
      if (cnt_cur != 2'b00) cnt_d = cnt_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bht_q[i] <= 2'b01;
    end else if (upd_en) begin
      bht_q[pc_from_rob_bus] <= cnt_d;
    end
  end

  always_comb begin
    pred_valid_d = pred_valid_q;
    pred_taken_d = pred_taken_q;
    upd_cnt_d    = upd_cnt_q;
    mis_cnt_d    = mis_cnt_q;
    if (rdy) begin
      pred_valid_d = accept;
      if (accept)
        pred_taken_d = bht_q[query_pc_from_inst_fetcher][1];
    end
    if (upd_en) begin
      if (upd_cnt_q != '1) upd_cnt_d = upd_cnt_q + 1'b1;
      if (mispred && (mis_cnt_q != '1))
        mis_cnt_d = mis_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      upd_cnt_q    <= '0;
      mis_cnt_q    <= '0;
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      upd_cnt_q    <= upd_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
    end
  end

  assign pred_valid_to_inst_fetcher = pred_valid_q;
  assign pred_taken_to_inst_fetcher = pred_taken_q;
  assign update_count               = upd_cnt_q;
  assign mispredict_count           = mis_cnt_q;

endmodule

// File: tb/tb_br_predictor.sv
// Bench for br_predictor: directed scenarios then random traffic, all
// checked against a table-of-integers reference model.
module tb_br_predictor;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic       qv;
  logic [7:0] qpc;
  logic       uv;
  logic [7:0] upc;
  logic       utk;
  logic       fl;

  logic        pv, pt, pv2, pt2;
  logic [31:0] uc, mc;
  logic [1:0]  uc2, mc2;

  int     tests = 0;
  int     fails = 0;
  int     m_tbl [256];
  longint m_uc, m_mc, m_uc2, m_mc2;
  logic   m_pv, m_pt;

  always #5 clk = ~clk;

  br_predictor dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .query_valid_from_inst_fetcher(qv),
    .query_pc_from_inst_fetcher(qpc),
    .valid_from_rob_bus(uv),
    .pc_from_rob_bus(upc),
    .is_taken_from_rob_bus(utk),
    .reset_from_rob_bus(fl),
    .pred_valid_to_inst_fetcher(pv),
    .pred_taken_to_inst_fetcher(pt),
    .update_count(uc),
    .mispredict_count(mc)
  );

  br_predictor #(.STAT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .rdy(rdy),
    .query_valid_from_inst_fetcher(qv),
    .query_pc_from_inst_fetcher(qpc),
    .valid_from_rob_bus(uv),
    .pc_from_rob_bus(upc),
    .is_taken_from_rob_bus(utk),
    .reset_from_rob_bus(fl),
    .pred_valid_to_inst_fetcher(pv2),
    .pred_taken_to_inst_fetcher(pt2),
    .update_count(uc2),
    .mispredict_count(mc2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_tbl[i] = 1;
    m_uc = 0; m_mc = 0; m_uc2 = 0; m_mc2 = 0;
    m_pv = 0; m_pt = 0;
  endtask

  // Apply one rising edge to the model using the current inputs
  task automatic model_edge();
    bit taken_pre;
    if (!rdy) return;
    if (qv && !fl) begin
      m_pv = 1;
      m_pt = (m_tbl[qpc] >= 2);
    end else begin
      m_pv = 0;
    end
    if (uv) begin
      taken_pre = (m_tbl[upc] >= 2);
      if (utk) m_tbl[upc] = (m_tbl[upc] < 3) ? m_tbl[upc] + 1 : 3;
      else     m_tbl[upc] = (m_tbl[upc] > 0) ? m_tbl[upc] - 1 : 0;
      m_uc  = (m_uc  < 64'hFFFF_FFFF) ? m_uc + 1 : m_uc;
      m_uc2 = (m_uc2 < 3) ? m_uc2 + 1 : m_uc2;
      if (taken_pre != utk) begin
        m_mc  = (m_mc  < 64'hFFFF_FFFF) ? m_mc + 1 : m_mc;
        m_mc2 = (m_mc2 < 3) ? m_mc2 + 1 : m_mc2;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pv"},  pv,  m_pv);
    chk({tag, ".pt"},  pt,  m_pt);
    chk({tag, ".uc"},  uc,  m_uc);
    chk({tag, ".mc"},  mc,  m_mc);
    chk({tag, ".pv2"}, pv2, m_pv);
    chk({tag, ".uc2"}, uc2, m_uc2);
    chk({tag, ".mc2"}, mc2, m_mc2);
  endtask

  task automatic cyc(input logic q, input logic [7:0] qi,
                     input logic u, input logic [7:0] ui,
                     input logic t, input logic f,
                     input logic r, input string tag);
    rdy = r; qv = q; qpc = qi; uv = u; upc = ui; utk = t; fl = f;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk({tag, ".pv"}, pv, 1'b0);
    chk({tag, ".pt"}, pt, 1'b0);
    chk({tag, ".uc"}, uc, 64'd0);
    chk({tag, ".mc"}, mc, 64'd0);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; qv = 0; qpc = 0;
    uv = 0; upc = 0; utk = 0; fl = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // cold query
    cyc(1, 5, 0, 0, 0, 0, 1, "cold_q");
    chk("cold_pv", pv, 1'b1);
    chk("cold_pt", pt, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 1, "cold_idle");
    chk("cold_pv_drop", pv, 1'b0);

    // training and saturation
    repeat (3) cyc(0, 0, 1, 7, 1, 0, 1, "train_t");
    cyc(1, 7, 0, 0, 0, 0, 1, "train_q1");
    chk("train_strong_pt", pt, 1'b1);
    cyc(0, 0, 1, 7, 0, 0, 1, "train_nt");
    cyc(1, 7, 0, 0, 0, 0, 1, "train_q2");
    chk("train_weak_pt", pt, 1'b1);
    chk("train_uc", uc, 64'd4);
    chk("train_mc", mc, 64'd2);

    // read-before-write collision
    cyc(1, 9, 1, 9, 1, 0, 1, "coll");
    chk("coll_pt_pre", pt, 1'b0);
    cyc(1, 9, 0, 0, 0, 0, 1, "coll_re");
    chk("coll_pt_post", pt, 1'b1);
    chk("stat_sat_uc2", uc2, 2'd3);

    // flush with simultaneous update
    cyc(1, 3, 1, 3, 1, 1, 1, "flush");
    chk("flush_pv", pv, 1'b0);
    chk("flush_uc", uc, 64'd6);

    // stall: prior prediction must hold, inputs ignored
    cyc(1, 9, 0, 0, 0, 0, 1, "pre_stall");
    cyc(1, 5, 1, 9, 0, 0, 0, "stall");
    chk("stall_pv", pv, 1'b1);
    chk("stall_uc", uc, 64'd6);
    cyc(1, 9, 0, 0, 0, 0, 1, "post_stall");
    chk("stall_tbl", pt, 1'b1);

    // asynchronous reset between edges
    async_reset("arst");
    cyc(1, 9, 0, 0, 0, 0, 1, "arst_q");
    chk("arst_pt", pt, 1'b0);
    cyc(0, 0, 1, 9, 1, 0, 1, "arst_upd");
    cyc(1, 9, 0, 0, 0, 0, 1, "arst_q2");
    chk("arst_weak", pt, 1'b1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      cyc(1'($urandom_range(0, 1)), a,
          1'($urandom_range(0, 1)), b,
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) != 0), "rand");
      if ($urandom_range(0, 499) == 0) async_reset("rand_arst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
